// File: rtl/vram_write_fifo_if.sv
// Drain-side handshake between the VRAM write FIFO and the video-memory consumer.
// The FIFO drives the master side and the consumer drives the slave side.
interface vram_write_fifo_if;
  logic        vram_wr_valid;
  logic [14:0] vram_wr_address;
  logic [7:0]  vram_wr_data;
  logic        vram_wr_ready;

  modport master (
    output vram_wr_valid,
    output vram_wr_address,
    output vram_wr_data,
    input  vram_wr_ready
  );

  modport slave (
    input  vram_wr_valid,
    input  vram_wr_address,
    input  vram_wr_data,
    output vram_wr_ready
  );
endinterface

// File: rtl/vram_write_fifo.sv
// Captures CPU byte writes to the CGA window into a small FWFT FIFO and drains them over valid/ready.
// Optional feature: define VRAM_FIFO_COALESCE_EN to merge repeated writes to the tail entry's offset.
module vram_write_fifo #(
  parameter int         DEPTH_LOG2 = 4,
  parameter logic [4:0] WINDOW_TAG = 5'h17
) (
  input  logic                  sdram_clock,
  input  logic                  sdram_reset,
  input  logic [19:0]           address,
  input  logic [7:0]            internal_data_bus,
  input  logic                  memory_write_n,
  output logic                  vram_write_ready,
  vram_write_fifo_if.master     vram_wr,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  overflow,
  input  logic                  overflow_clear
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int EW    = 23;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [CW-1:0]         cnt_t;
  typedef logic [EW-1:0]         entry_t;

  localparam ptr_t   PTR_ZERO    = {DEPTH_LOG2{1'b0}};
  localparam ptr_t   PTR_ONE     = ptr_t'(1'b1);
  localparam cnt_t   CNT_ZERO    = {CW{1'b0}};
  localparam cnt_t   CNT_ONE     = cnt_t'(1'b1);
  localparam cnt_t   CNT_TWO     = cnt_t'(2'd2);
  localparam cnt_t   CNT_FULL    = cnt_t'(DEPTH);
  localparam cnt_t   CNT_AFULL   = cnt_t'(DEPTH - 1);
  localparam entry_t ENTRY_ZERO  = {EW{1'b0}};

  // Bus synchroniser stages; address/data ride one stage behind nothing, aligned with wr1/wr2.
  logic        wr1_q, wr1_d, wr2_q, wr2_d, wr3_q, wr3_d;
  logic [19:0] a1_q, a1_d, a2_q, a2_d;
  logic [7:0]  d1_q, d1_d, d2_q, d2_d;

  // FIFO storage and bookkeeping.
  entry_t entry_q [DEPTH];
  entry_t entry_d [DEPTH];
  ptr_t   wr_ptr_q, wr_ptr_d;
  ptr_t   rd_ptr_q, rd_ptr_d;
  cnt_t   count_q, count_d;
  logic   overflow_q, overflow_d;
  logic   write_ready_q, write_ready_d;

  logic   push_req;
  logic   pop;
  logic   full;
  logic   coalesce;
  logic   drop;
  logic   mem_we;
  ptr_t   mem_waddr;
  ptr_t   tail_ptr;
  entry_t new_entry;

  // Next-state of the synchroniser chain.
  always_comb begin
    wr1_d = ~memory_write_n;
    wr2_d = wr1_q;
    wr3_d = wr2_q;
    a1_d  = address;
    a2_d  = a1_q;
    d1_d  = internal_data_bus;
    d2_d  = d1_q;
  end

  // Push/pop decode and FIFO next-state.
  always_comb begin
    push_req  = wr2_q & ~wr3_q & (a2_q[19:15] == WINDOW_TAG);
    pop       = (count_q != CNT_ZERO) & vram_wr.vram_wr_ready;
    full      = (count_q == CNT_FULL);
    tail_ptr  = wr_ptr_q - PTR_ONE;
    new_entry = {a2_q[14:0], d2_q};
    coalesce  = 1'b0;
`ifdef VRAM_FIFO_COALESCE_EN
    // Never touch the tail while it is also the head being offered to the consumer.
    coalesce  = push_req & (count_q >= CNT_TWO) & (entry_q[tail_ptr][22:8] == a2_q[14:0]);
`else
    coalesce  = 1'b0;
`endif
    drop      = push_req & ~coalesce & full & ~pop;

    wr_ptr_d  = wr_ptr_q;
    mem_we    = 1'b0;
    mem_waddr = wr_ptr_q;
    count_d   = count_q;

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (coalesce) begin
      mem_we    = 1'b1;
      mem_waddr = tail_ptr;
      count_d   = pop ? (count_q - CNT_ONE) : count_q;
    end else if (push_req && (!full || pop)) begin
      mem_we    = 1'b1;
      mem_waddr = wr_ptr_q;
      wr_ptr_d  = wr_ptr_q + PTR_ONE;
      count_d   = pop ? count_q : (count_q + CNT_ONE);
    end else begin
      count_d   = pop ? (count_q - CNT_ONE) : count_q;
    end

    if (drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clear) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    write_ready_d = (count_d >= CNT_AFULL) ? 1'b0 : 1'b1;
  end

  // Storage array next-state: a single write port.
  always_comb begin
    entry_d = entry_q;
    if (mem_we) begin
      entry_d[mem_waddr] = new_entry;
    end else begin
      entry_d = entry_q;
    end
  end

  // All state registers; reset discards every entry at once.
  always_ff @(posedge sdram_clock or posedge sdram_reset) begin
    if (sdram_reset) begin
      wr1_q         <= 1'b0;
      wr2_q         <= 1'b0;
      wr3_q         <= 1'b0;
      a1_q          <= 20'h00000;
      a2_q          <= 20'h00000;
      d1_q          <= 8'h00;
      d2_q          <= 8'h00;
      wr_ptr_q      <= PTR_ZERO;
      rd_ptr_q      <= PTR_ZERO;
      count_q       <= CNT_ZERO;
      overflow_q    <= 1'b0;
      write_ready_q <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= ENTRY_ZERO;
      end
    end else begin
      wr1_q         <= wr1_d;
      wr2_q         <= wr2_d;
      wr3_q         <= wr3_d;
      a1_q          <= a1_d;
      a2_q          <= a2_d;
      d1_q          <= d1_d;
      d2_q          <= d2_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      write_ready_q <= write_ready_d;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  // Head is read straight from the array, giving first-word-fall-through behaviour.
  assign vram_wr.vram_wr_valid   = (count_q != CNT_ZERO);
  assign vram_wr.vram_wr_address = entry_q[rd_ptr_q][22:8];
  assign vram_wr.vram_wr_data    = entry_q[rd_ptr_q][7:0];
  assign fifo_level              = count_q;
  assign overflow                = overflow_q;
  assign vram_write_ready        = write_ready_q;

endmodule

// File: tb/tb_vram_write_fifo.sv
// Self-checking bench for vram_write_fifo: directed scenarios plus randomized rounds
// checked against a queue-based model of the FIFO contents and the sticky overflow flag.
module tb_vram_write_fifo;

  logic        sdram_clock = 1'b0;
  logic        sdram_reset;
  logic [19:0] address;
  logic [7:0]  internal_data_bus;
  logic        memory_write_n;
  logic        vram_write_ready;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic        overflow_clear;

  vram_write_fifo_if vif ();

  vram_write_fifo #(.DEPTH_LOG2(4), .WINDOW_TAG(5'h17)) dut (
    .sdram_clock       (sdram_clock),
    .sdram_reset       (sdram_reset),
    .address           (address),
    .internal_data_bus (internal_data_bus),
    .memory_write_n    (memory_write_n),
    .vram_write_ready  (vram_write_ready),
    .vram_wr           (vif),
    .fifo_level        (fifo_level),
    .overflow          (overflow),
    .overflow_clear    (overflow_clear)
  );

  always #5 sdram_clock = ~sdram_clock;

  int          checks = 0;
  int          errors = 0;
  logic [22:0] q[$];
  logic [22:0] got_q[$];
  bit          model_ovf;
  bit          drain_timeout;

  // Reference model: one hit write = one new {offset,data} entry unless full (then dropped).
  function automatic void model_push(input logic [19:0] a, input logic [7:0] d);
    logic [22:0] t;
    if (a[19:15] != 5'h17) return;
`ifdef VRAM_FIFO_COALESCE_EN
    if (q.size() >= 2 && q[q.size()-1][22:8] == a[14:0]) begin
      t = q.pop_back();
      t[7:0] = d;
      q.push_back(t);
      return;
    end
`endif
    if (q.size() < 16) q.push_back({a[14:0], d});
    else model_ovf = 1'b1;
  endfunction

  task automatic tick();
    @(posedge sdram_clock);
    #1;
  endtask

  task automatic do_reset();
    sdram_reset = 1'b1;
    memory_write_n = 1'b1;
    address = 20'h00000;
    internal_data_bus = 8'h00;
    overflow_clear = 1'b0;
    vif.vram_wr_ready = 1'b0;
    repeat (3) tick();
    sdram_reset = 1'b0;
    tick();
    q.delete();
    model_ovf = 1'b0;
  endtask

  // One CPU bus write; afterwards the write has fully settled in the FIFO.
  task automatic cpu_write(input logic [19:0] a, input logic [7:0] d, input int len);
    address = a;
    internal_data_bus = d;
    memory_write_n = 1'b0;
    repeat (len) tick();
    memory_write_n = 1'b1;
    repeat (3) tick();
    model_push(a, d);
  endtask

  // Consume entries until the FIFO offers nothing; collected entries land in got_q.
  task automatic drain_collect(input bit rnd);
    drain_timeout = 1'b0;
    got_q.delete();
    for (int c = 0; c < 400; c++) begin
      if (vif.vram_wr_valid !== 1'b1) begin
        vif.vram_wr_ready = 1'b0;
        return;
      end
      vif.vram_wr_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (vif.vram_wr_ready) got_q.push_back({vif.vram_wr_address, vif.vram_wr_data});
      tick();
    end
    vif.vram_wr_ready = 1'b0;
    drain_timeout = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (vif.vram_wr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", vif.vram_wr_valid); end
    checks++; if (vif.vram_wr_address !== 15'h0000) begin errors++; $display("FAIL reset_addr got %h exp 0000", vif.vram_wr_address); end
    checks++; if (vif.vram_wr_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", vif.vram_wr_data); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    checks++; if (vram_write_ready !== 1'b1) begin errors++; $display("FAIL reset_write_ready got %b exp 1", vram_write_ready); end
  endtask

  task automatic test_single_write();
    logic [2:0] exp_valid;
    do_reset();
    vif.vram_wr_ready = 1'b1;
    address = 20'hB8123;
    internal_data_bus = 8'h5A;
    memory_write_n = 1'b0;
    exp_valid = 3'b000;
    for (int e = 1; e <= 4; e++) begin
      tick();
      if (e == 1) memory_write_n = 1'b1;
      checks++;
      if (vif.vram_wr_valid !== (e == 3)) begin
        errors++; $display("FAIL single_valid_E%0d got %b exp %b", e, vif.vram_wr_valid, (e == 3));
      end
      if (e == 3) begin
        checks++;
        if (vif.vram_wr_address !== 15'h0123 || vif.vram_wr_data !== 8'h5A) begin
          errors++; $display("FAIL single_entry got %h/%h exp 0123/5a", vif.vram_wr_address, vif.vram_wr_data);
        end
      end
    end
    vif.vram_wr_ready = 1'b0;
  endtask

  task automatic test_window_filter();
    logic [19:0] miss [3];
    miss[0] = 20'hB0000; miss[1] = 20'hC0000; miss[2] = 20'hB7FFF;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cpu_write(miss[i], 8'(i + 1), 2);
      checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL window_miss_%0d level got %0d exp 0", i, fifo_level); end
    end
    cpu_write(20'hBFFFF, 8'hC3, 1);
    checks++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL window_hit level got %0d exp 1", fifo_level); end
    checks++;
    if (vif.vram_wr_address !== 15'h7FFF || vif.vram_wr_data !== 8'hC3) begin
      errors++; $display("FAIL window_hit_entry got %h/%h exp 7fff/c3", vif.vram_wr_address, vif.vram_wr_data);
    end
  endtask

  task automatic test_fill_overflow();
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cpu_write({5'h17, 15'(i)}, 8'($urandom), 1);
      checks++;
      if (fifo_level !== 5'(q.size()) || vram_write_ready !== (q.size() < 15)) begin
        errors++; $display("FAIL fill_%0d level/ready got %0d/%b exp %0d/%b", i, fifo_level, vram_write_ready, q.size(), (q.size() < 15));
      end
    end
    checks++; if (overflow !== 1'b1 || fifo_level !== 5'd16) begin errors++; $display("FAIL fill_overflow got %b/%0d exp 1/16", overflow, fifo_level); end
    overflow_clear = 1'b1;
    tick();
    overflow_clear = 1'b0;
    model_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear got %b exp 0", overflow); end
    // Drop coinciding with a clear request: the set must win.
    d = 8'($urandom);
    address = 20'hBF000; internal_data_bus = d; memory_write_n = 1'b0;
    tick(); memory_write_n = 1'b1;
    tick(); overflow_clear = 1'b1;
    tick(); overflow_clear = 1'b0;
    model_push(20'hBF000, d);
    checks++; if (overflow !== 1'b1 || fifo_level !== 5'd16) begin errors++; $display("FAIL set_wins got %b/%0d exp 1/16", overflow, fifo_level); end
    repeat (2) tick();
    drain_collect(1'b0);
    checks++;
    if (drain_timeout || got_q.size() != q.size()) begin
      errors++; $display("FAIL fill_drain_count got %0d exp %0d timeout %0d", got_q.size(), q.size(), drain_timeout);
    end else begin
      for (int i = 0; i < q.size(); i++) begin
        checks++; if (got_q[i] !== q[i]) begin errors++; $display("FAIL fill_drain_%0d got %h exp %h", i, got_q[i], q[i]); end
      end
    end
    q.delete();
  endtask

  task automatic test_full_with_pop();
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 16; i++) cpu_write({5'h17, 15'(16'h0100 + i)}, 8'($urandom), 1);
    d = 8'($urandom);
    address = 20'hBA5A5; internal_data_bus = d; memory_write_n = 1'b0;
    tick(); memory_write_n = 1'b1;
    tick(); vif.vram_wr_ready = 1'b1;
    tick(); vif.vram_wr_ready = 1'b0;
    void'(q.pop_front());
    model_push(20'hBA5A5, d);
    checks++; if (fifo_level !== 5'd16 || overflow !== 1'b0) begin errors++; $display("FAIL full_pop level/ovf got %0d/%b exp 16/0", fifo_level, overflow); end
    repeat (2) tick();
    drain_collect(1'b1);
    checks++;
    if (drain_timeout || got_q.size() != q.size()) begin
      errors++; $display("FAIL full_pop_count got %0d exp %0d timeout %0d", got_q.size(), q.size(), drain_timeout);
    end else begin
      for (int i = 0; i < q.size(); i++) begin
        checks++; if (got_q[i] !== q[i]) begin errors++; $display("FAIL full_pop_%0d got %h exp %h", i, got_q[i], q[i]); end
      end
    end
    q.delete();
  endtask

  task automatic test_long_strobe();
    do_reset();
    cpu_write(20'hB9ABC, 8'h77, 10);
    checks++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL long_strobe level got %0d exp 1", fifo_level); end
    checks++;
    if (vif.vram_wr_address !== 15'h1ABC || vif.vram_wr_data !== 8'h77) begin
      errors++; $display("FAIL long_strobe_entry got %h/%h exp 1abc/77", vif.vram_wr_address, vif.vram_wr_data);
    end
  endtask

  task automatic test_coalesce();
    int exp_level;
`ifdef VRAM_FIFO_COALESCE_EN
    exp_level = 2;
`else
    exp_level = 4;
`endif
    do_reset();
    cpu_write(20'hB8010, 8'h01, 1);
    cpu_write(20'hB8020, 8'h02, 1);
    cpu_write(20'hB8020, 8'h11, 2);
    cpu_write(20'hB8020, 8'h22, 1);
    checks++; if (fifo_level !== 5'(exp_level)) begin errors++; $display("FAIL coalesce_level got %0d exp %0d", fifo_level, exp_level); end
    drain_collect(1'b0);
    checks++;
    if (drain_timeout || got_q.size() != exp_level) begin
      errors++; $display("FAIL coalesce_count got %0d exp %0d", got_q.size(), exp_level);
    end else begin
      checks++;
      if (got_q[exp_level-1] !== {15'h0020, 8'h22}) begin
        errors++; $display("FAIL coalesce_tail got %h exp %h", got_q[exp_level-1], {15'h0020, 8'h22});
      end
    end
    q.delete();
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    for (int i = 0; i < 3; i++) cpu_write({5'h17, 15'(16'h0200 + i)}, 8'(i), 1);
    #2 sdram_reset = 1'b1;
    #1;
    checks++;
    if (fifo_level !== 5'd0 || vif.vram_wr_valid !== 1'b0 || vif.vram_wr_address !== 15'h0000) begin
      errors++; $display("FAIL mid_reset got %0d/%b/%h exp 0/0/0000", fifo_level, vif.vram_wr_valid, vif.vram_wr_address);
    end
    tick();
    sdram_reset = 1'b0;
    q.delete();
    tick();
  endtask

  task automatic test_random();
    logic [19:0] a;
    logic [14:0] off;
    logic [4:0]  tag;
    int          k;
    do_reset();
    for (int r = 0; r < 8; r++) begin
      vif.vram_wr_ready = 1'b0;
      k = $urandom_range(1, 20);
      for (int w = 0; w < k; w++) begin
        off = ($urandom_range(0, 1) != 0) ? 15'($urandom_range(0, 3) * 16) : 15'($urandom);
        tag = 5'h17;
        if ($urandom_range(0, 3) == 0) begin
          tag = 5'($urandom);
          if (tag == 5'h17) tag = 5'h18;
        end
        a = {tag, off};
        cpu_write(a, 8'($urandom), $urandom_range(1, 4));
        checks++;
        if (fifo_level !== 5'(q.size()) || vram_write_ready !== (q.size() < 15)) begin
          errors++; $display("FAIL rnd_r%0d_w%0d level/ready got %0d/%b exp %0d/%b", r, w, fifo_level, vram_write_ready, q.size(), (q.size() < 15));
        end
      end
      checks++; if (overflow !== model_ovf) begin errors++; $display("FAIL rnd_r%0d_overflow got %b exp %b", r, overflow, model_ovf); end
      overflow_clear = 1'b1; tick(); overflow_clear = 1'b0; model_ovf = 1'b0;
      drain_collect(1'b1);
      checks++;
      if (drain_timeout || got_q.size() != q.size()) begin
        errors++; $display("FAIL rnd_r%0d_count got %0d exp %0d timeout %0d", r, got_q.size(), q.size(), drain_timeout);
      end else begin
        for (int i = 0; i < q.size(); i++) begin
          checks++; if (got_q[i] !== q[i]) begin errors++; $display("FAIL rnd_r%0d_e%0d got %h exp %h", r, i, got_q[i], q[i]); end
        end
      end
      q.delete();
      checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL rnd_r%0d_empty got %0d exp 0", r, fifo_level); end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_window_filter();
    test_fill_overflow();
    test_full_with_pop();
    test_long_strobe();
    test_coalesce();
    test_reset_mid_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
